// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel edge detector: register offsets,
// default kernels, pixel/window types, FSM states and small helpers.
package sobel_pkg;

  // Register byte offsets
  localparam logic [7:0] REG_THRESH = 8'h00;
  localparam logic [7:0] REG_WIDTH  = 8'h04;
  localparam logic [7:0] REG_HEIGHT = 8'h08;
  localparam logic [7:0] REG_TOTAL  = 8'h0C;
  localparam logic [7:0] REG_KERN1  = 8'h10;
  localparam logic [7:0] REG_KERN2  = 8'h14;
  localparam logic [7:0] REG_KERN3  = 8'h18;
  localparam logic [7:0] REG_KERN4  = 8'h1C;
  localparam logic [7:0] REG_CTRL   = 8'h20;
  localparam logic [7:0] REG_STATUS = 8'h24;

  // Default kernels, k0 (top-left) in [26:24] down to k8 (bottom-right) in [2:0]
  // Gx = [-1 0 1; -2 0 2; -1 0 1]
  localparam logic [26:0] SOBEL_GX = {3'b111, 3'b000, 3'b001,
                                      3'b110, 3'b000, 3'b010,
                                      3'b111, 3'b000, 3'b001};
  // Gy = [-1 -2 -1; 0 0 0; 1 2 1]
  localparam logic [26:0] SOBEL_GY = {3'b111, 3'b110, 3'b111,
                                      3'b000, 3'b000, 3'b000,
                                      3'b001, 3'b010, 3'b001};

  typedef logic signed [2:0] coeff_t;
  typedef logic [7:0]        pixel_t;
  // Element 0 is the top-left pixel, element 8 the bottom-right (row-major)
  typedef pixel_t [8:0]      window_t;

  // Frame control states; busy = ST_RUN, done = ST_DONE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Extract coefficient idx (0..8, row-major) from a packed kernel
  function automatic coeff_t kern_coeff(input logic [26:0] k, input int idx);
    return k[26-3*idx -: 3];
  endfunction

  // Absolute value of a 15-bit signed response, as unsigned 15 bits
  function automatic logic [14:0] abs15(input logic signed [14:0] v);
    return v[14] ? 15'(-v) : 15'(v);
  endfunction

endpackage

// File: rtl/sobel_conv3x3.sv
// Combinational 3x3 window x signed kernel dot product.
module sobel_conv3x3
  import sobel_pkg::*;
(
  input  window_t            win_i,
  input  logic [26:0]        kern_i,
  output logic signed [14:0] resp_o
);

  logic signed [14:0] acc;
  logic signed [14:0] pix_s;
  logic signed [14:0] coef_s;
  coeff_t             coef;

  // Sum of nine unsigned-pixel x signed-coefficient products; max |sum| is
  // 9*255*4, which fits a 15-bit signed accumulator.
  always_comb begin
    acc    = '0;
    pix_s  = '0;
    coef_s = '0;
    coef   = '0;
    for (int i = 0; i < 9; i++) begin
      coef   = kern_coeff(kern_i, i);
      pix_s  = $signed({7'b0, win_i[i]});
      coef_s = {{12{coef[2]}}, coef};
      acc    = acc + pix_s * coef_s;
    end
    resp_o = acc;
  end

endmodule

// File: rtl/sobel_top.sv
// APB-configured streaming 3x3 edge detector. Two line buffers feed a 3x3
// window register; four kernels are applied, absolute responses summed and
// thresholded into a binary edge pixel for every interior pixel.
// Valid/ready: the pixel stream has no backpressure; a beat is taken on any
// clk edge where valid_in is high, the frame is busy and fewer than
// total_pixels beats have been taken. valid_out is a one-cycle strobe per result.
module sobel_top
  import sobel_pkg::*;
#(
  parameter int MAX_WIDTH = 1024,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  pixel_t            pixel_in,
  input  logic              valid_in,
  output pixel_t            pixel_out,
  output logic              valid_out,
  output logic              sobel_done
);

  localparam int LB_AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  // ---------------- APB decode ----------------
  logic        addr_ok;
  logic [3:0]  reg_idx;
  logic        wr_en;
  logic        start;
  logic [31:0] rdata;

  assign addr_ok = (PADDR[1:0] == 2'b00) && (PADDR <= ADDR_W'(REG_STATUS));
  assign reg_idx = PADDR[5:2];
  assign wr_en   = PSEL & PENABLE & PWRITE & addr_ok;
  assign start   = wr_en && (reg_idx == REG_CTRL[5:2]) && PWDATA[0];
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & ~addr_ok;

  // ---------------- Configuration registers ----------------
  logic [15:0] thresh_q;
  logic [15:0] width_q;
  logic [15:0] height_q;
  logic [31:0] total_q;
  logic [26:0] kern_q [4];

  // Register file writes; control is a pulse and holds no storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thresh_q <= '0;
      width_q  <= '0;
      height_q <= '0;
      total_q  <= '0;
      for (int i = 0; i < 4; i++) kern_q[i] <= '0;
    end else if (wr_en) begin
      case (reg_idx)
        REG_THRESH[5:2]: thresh_q  <= PWDATA[15:0];
        REG_WIDTH[5:2]:  width_q   <= PWDATA[15:0];
        REG_HEIGHT[5:2]: height_q  <= PWDATA[15:0];
        REG_TOTAL[5:2]:  total_q   <= PWDATA[31:0];
        REG_KERN1[5:2]:  kern_q[0] <= PWDATA[26:0];
        REG_KERN2[5:2]:  kern_q[1] <= PWDATA[26:0];
        REG_KERN3[5:2]:  kern_q[2] <= PWDATA[26:0];
        REG_KERN4[5:2]:  kern_q[3] <= PWDATA[26:0];
        default: ;
      endcase
    end
  end

  // ---------------- Frame FSM ----------------
  state_t state_q, state_d;
  logic   busy;
  logic   done;
  logic   drained;
  logic   s1_v_q;
  logic   s2_v_q;
  logic [31:0] count_q;

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign drained = (count_q >= total_q) && !s1_v_q && !s2_v_q;

  // Read mux: combinational whenever a read is selected
  always_comb begin
    rdata = '0;
    if (PSEL && !PWRITE && addr_ok) begin
      case (reg_idx)
        REG_THRESH[5:2]: rdata = {16'b0, thresh_q};
        REG_WIDTH[5:2]:  rdata = {16'b0, width_q};
        REG_HEIGHT[5:2]: rdata = {16'b0, height_q};
        REG_TOTAL[5:2]:  rdata = total_q;
        REG_KERN1[5:2]:  rdata = {5'b0, kern_q[0]};
        REG_KERN2[5:2]:  rdata = {5'b0, kern_q[1]};
        REG_KERN3[5:2]:  rdata = {5'b0, kern_q[2]};
        REG_KERN4[5:2]:  rdata = {5'b0, kern_q[3]};
        REG_STATUS[5:2]: rdata = {30'b0, done, busy};
        default:         rdata = '0;
      endcase
    end
  end
  assign PRDATA = DATA_W'(rdata);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: start always (re)enters RUN; RUN ends once all pixels are
  // taken and nothing is left in the pipeline
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: ;
      ST_RUN:  if (drained) state_d = ST_DONE;
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
    if (start) state_d = ST_RUN;
  end

  assign sobel_done = done;

  // ---------------- Raster position ----------------
  logic [15:0] eff_w;
  logic [15:0] col_q;
  logic [15:0] row_q;
  logic        accept;
  logic        col_last;
  logic        emit;

  assign eff_w    = (width_q > 16'(MAX_WIDTH)) ? 16'(MAX_WIDTH) : width_q;
  assign accept   = valid_in && busy && (count_q < total_q);
  assign col_last = (col_q + 16'd1) >= eff_w;
  // A centre result exists once two full rows and two columns are behind us
  assign emit     = accept && (row_q >= 16'd2) && (col_q >= 16'd2) && (row_q < height_q);

  // Column/row/pixel counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      count_q <= '0;
    end else if (start) begin
      col_q   <= '0;
      row_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 32'd1;
      if (col_last) begin
        col_q <= '0;
        row_q <= row_q + 16'd1;
      end else begin
        col_q <= col_q + 16'd1;
      end
    end
  end

  // ---------------- Line buffers ----------------
  // Contents are only ever read after being written in the same frame, so
  // the storage arrays carry no reset.
  pixel_t            lb_top [MAX_WIDTH];
  pixel_t            lb_mid [MAX_WIDTH];
  logic [LB_AW-1:0]  lb_addr;
  pixel_t            top_pix;
  pixel_t            mid_pix;

  assign lb_addr = col_q[LB_AW-1:0];
  assign top_pix = lb_top[lb_addr];
  assign mid_pix = lb_mid[lb_addr];

  // Row r-1 moves up to the top buffer as row r overwrites the middle one
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[lb_addr] <= mid_pix;
      lb_mid[lb_addr] <= pixel_in;
    end
  end

  // ---------------- Window (stage 0) ----------------
  window_t win_q;

  // Shift the window left by one column and insert the new column on the right
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q  <= '0;
      s1_v_q <= 1'b0;
    end else begin
      s1_v_q <= start ? 1'b0 : emit;
      if (accept) begin
        win_q <= {pixel_in, win_q[8], win_q[7],
                  mid_pix,  win_q[5], win_q[4],
                  top_pix,  win_q[2], win_q[1]};
      end
    end
  end

  // ---------------- Convolution and magnitude (stage 1) ----------------
  logic [26:0]        kern_eff [4];
  logic signed [14:0] resp [4];
  logic [16:0]        mag_d;
  logic [16:0]        mag_q;

  // Zero kernels fall back to Sobel Gx/Gy; kernels 3/4 at zero contribute 0
  assign kern_eff[0] = (kern_q[0] == 27'd0) ? SOBEL_GX : kern_q[0];
  assign kern_eff[1] = (kern_q[1] == 27'd0) ? SOBEL_GY : kern_q[1];
  assign kern_eff[2] = kern_q[2];
  assign kern_eff[3] = kern_q[3];

  sobel_conv3x3 u_conv0 (.win_i(win_q), .kern_i(kern_eff[0]), .resp_o(resp[0]));
  sobel_conv3x3 u_conv1 (.win_i(win_q), .kern_i(kern_eff[1]), .resp_o(resp[1]));
  sobel_conv3x3 u_conv2 (.win_i(win_q), .kern_i(kern_eff[2]), .resp_o(resp[2]));
  sobel_conv3x3 u_conv3 (.win_i(win_q), .kern_i(kern_eff[3]), .resp_o(resp[3]));

  assign mag_d = {2'b0, abs15(resp[0])} + {2'b0, abs15(resp[1])}
               + {2'b0, abs15(resp[2])} + {2'b0, abs15(resp[3])};

  // Register the magnitude alongside its valid flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag_q  <= '0;
      s2_v_q <= 1'b0;
    end else begin
      s2_v_q <= start ? 1'b0 : s1_v_q;
      if (s1_v_q) mag_q <= mag_d;
    end
  end

  // ---------------- Threshold and output (stage 2) ----------------
  pixel_t pix_out_q;
  logic   vout_q;

  // Binary edge decision, strobed for one cycle per result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_out_q <= '0;
      vout_q    <= 1'b0;
    end else begin
      vout_q    <= s2_v_q && !start;
      pix_out_q <= (s2_v_q && (mag_q > {1'b0, thresh_q})) ? 8'hFF : 8'h00;
    end
  end

  assign pixel_out = pix_out_q;
  assign valid_out = vout_q;

endmodule

// File: tb/tb_sobel_top.sv
// Directed bench for sobel_top: APB register checks, mid-frame reset,
// and full frames compared against a behavioural convolution model.
module tb_sobel_top;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  pixel_in = '0;
  logic        valid_in = 1'b0;
  logic [7:0]  pixel_out;
  logic        valid_out;
  logic        sobel_done;

  sobel_top dut (
    .clk(clk), .reset_n(reset_n),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .pixel_in(pixel_in), .valid_in(valid_in),
    .pixel_out(pixel_out), .valid_out(valid_out), .sobel_done(sobel_done)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // ---------------- behavioural model ----------------
  int img [100];
  int w, h, total, thr;
  int coef [4][9];
  int gx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int gy [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
  logic [7:0] exp_q [$];

  function automatic void load_coef(input int k, input logic [26:0] kv);
    int c;
    for (int i = 0; i < 9; i++) begin
      if (kv == 27'd0) begin
        if (k == 0)      coef[k][i] = gx[i];
        else if (k == 1) coef[k][i] = gy[i];
        else             coef[k][i] = 0;
      end else begin
        c = int'((kv >> (24 - 3*i)) & 27'd7);
        if (c >= 4) c = c - 8;
        coef[k][i] = c;
      end
    end
  endfunction

  // Sum of absolute kernel responses around centre (r,c)
  function automatic int model_mag(input int r, input int c);
    int m = 0;
    int s;
    for (int k = 0; k < 4; k++) begin
      s = 0;
      for (int i = 0; i < 9; i++)
        s += img[(r - 1 + i/3) * w + (c - 1 + i%3)] * coef[k][i];
      m += (s < 0) ? -s : s;
    end
    return m;
  endfunction

  function automatic void build_expect();
    exp_q.delete();
    for (int r = 1; r <= h - 2; r++)
      for (int c = 1; c <= w - 2; c++)
        exp_q.push_back((model_mag(r, c) > thr) ? 8'd255 : 8'd0);
  endfunction

  // ---------------- compare process ----------------
  bit         check_en = 1'b0;
  int         out_count = 0;
  int         first_valid = -1;
  logic [7:0] e_pix;

  always @(negedge clk) begin
    if (reset_n && check_en && valid_out) begin
      out_count++;
      if (first_valid < 0) first_valid = cyc;
      check("done_before_last", {31'b0, sobel_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("extra_output", {31'b0, valid_out}, 32'd0);
      end else begin
        e_pix = exp_q.pop_front();
        check("pixel_out", {24'b0, pixel_out}, {24'b0, e_pix});
      end
    end
  end

  // ---------------- APB driver tasks ----------------
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
    @(posedge clk); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    err = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic e;
    apb_write(addr, data, e);
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    @(posedge clk); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    data = PRDATA;
    err  = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] expv);
    logic [31:0] d;
    logic        e;
    apb_read(addr, d, e);
    check(name, d, expv);
  endtask

  // ---------------- pixel driver ----------------
  int e22 = -1;

  task automatic send_pixels(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      pixel_in = img[i][7:0];
      if (i == 22) e22 = cyc + 1;
      if (gap) begin
        @(posedge clk); #1;
        valid_in = 1'b0;
      end
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  // ---------------- frame runner ----------------
  task automatic run_frame(input int thr_v, input logic [26:0] k0, input logic [26:0] k1,
                           input logic [26:0] k2, input logic [26:0] k3,
                           input bit gap, input bit chk_lat, input int pin_mag);
    int i;
    w = 10; h = 10; total = 100; thr = thr_v;
    wr(32'h00, thr_v);
    wr(32'h04, w);
    wr(32'h08, h);
    wr(32'h0C, total);
    wr(32'h10, {5'b0, k0});
    wr(32'h14, {5'b0, k1});
    wr(32'h18, {5'b0, k2});
    wr(32'h1C, {5'b0, k3});
    load_coef(0, k0); load_coef(1, k1); load_coef(2, k2); load_coef(3, k3);
    build_expect();
    check("model_pin_mag", model_mag(1, 1), pin_mag);
    check("model_len", exp_q.size(), 64);
    out_count = 0;
    first_valid = -1;
    e22 = -1;
    check_en = 1'b1;
    wr(32'h20, 32'h1);
    send_pixels(total, gap);
    for (i = 0; i < 2000; i++) begin
      if (sobel_done) break;
      @(negedge clk);
    end
    check("done_timeout", {31'b0, sobel_done}, 32'd1);
    repeat (4) @(negedge clk);
    check("out_count", out_count, 64);
    check("exp_left", exp_q.size(), 0);
    if (chk_lat) check("first_latency", first_valid, e22 + 2);
    rd_check("status_done", 32'h24, 32'h2);
    check_en = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    logic        e;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Mid-frame reset
    for (int i = 0; i < 100; i++) img[i] = i + 1;
    wr(32'h00, 0); wr(32'h04, 10); wr(32'h08, 10); wr(32'h0C, 100);
    wr(32'h20, 1);
    send_pixels(40, 1'b0);
    @(posedge clk); #1;
    valid_in = 1'b1;
    pixel_in = 8'd41;
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid_out", {31'b0, valid_out}, 32'd0);
    check("rst_pixel_out", {24'b0, pixel_out}, 32'd0);
    check("rst_sobel_done", {31'b0, sobel_done}, 32'd0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    rd_check("rst_status", 32'h24, 32'h0);
    valid_in = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int a = 0; a <= 9; a++) rd_check("reg_after_reset", 32'(a * 4), 32'h0);

    // APB register behaviour
    wr(32'h00, 110);
    wr(32'h04, 573);
    wr(32'h10, 32'h05A5A5A5);
    rd_check("reg_thresh", 32'h00, 32'd110);
    rd_check("reg_width", 32'h04, 32'd573);
    rd_check("reg_kern1", 32'h10, 32'h05A5A5A5);
    wr(32'h20, 1);
    rd_check("reg_ctrl_reads0", 32'h20, 32'h0);
    rd_check("status_empty_frame", 32'h24, 32'h2);
    apb_write(32'h40, 32'd7, e);
    check("pslverr_wr_0x40", {31'b0, e}, 32'd1);
    apb_write(32'h01, 32'd5, e);
    check("pslverr_misaligned", {31'b0, e}, 32'd1);
    rd_check("thresh_unchanged", 32'h00, 32'd110);
    apb_read(32'h40, d, e);
    check("pslverr_rd_0x40", {31'b0, e}, 32'd1);

    // Ramp, default kernels: mag = 8 + 80 = 88
    run_frame(110, 27'd0, 27'd0, 27'd0, 27'd0, 1'b0, 1'b0, 88);
    run_frame(80,  27'd0, 27'd0, 27'd0, 27'd0, 1'b0, 1'b1, 88);
    run_frame(80,  27'd0, 27'd0, 27'd0, 27'd0, 1'b1, 1'b0, 88);

    // Flat image of 10 with an all-ones kernel: mag = 90
    for (int i = 0; i < 100; i++) img[i] = 10;
    run_frame(89, 27'h1249249, 27'd0, 27'd0, 27'd0, 1'b0, 1'b0, 90);
    run_frame(90, 27'h1249249, 27'd0, 27'd0, 27'd0, 1'b0, 1'b0, 90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
